pia_fifo: RTL and testbench
===========================

Name: pia_fifo

Overview:
- Next-generation Apple-I style PIA (keyboard input and display output) with parametrised data width and independent RX/TX FIFOs.
- Decouples host-side rdy/ack handshakes from the 6502 CPU bus.
- Adds overflow status, a FIFO fill-level readback and an optional keyboard interrupt.
- Sits on the CPU address/data bus beside RAM and the monitor ROM; its read data feeds the top-level read mux.

Parameters:
- BASE_ADDR, 16'hD010, CPU address of register 0; occupies BASE_ADDR..BASE_ADDR+3.
- DATA_W, 7, character width (1..8).
- KBD_DEPTH, 4, keyboard RX FIFO entries; power of two, at least 2.
- DSP_DEPTH, 4, display TX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  CPU clock; sole clock.
- reset  in  1  asynchronous, active-low reset.
- addr  in  16  CPU address bus.
- we  in  1  CPU write enable.
- din  in  8  CPU write data.
- dout  out  8  registered read data, valid the cycle after the address is presented.
- irq  out  1  keyboard interrupt request, active-high.
- kbd_rdy  in  1  host has a character on kbd_data.
- kbd_ack  out  1  character accepted.
- kbd_data  in  DATA_W  keyboard character.
- dsp_rdy  out  1  character valid on dsp_data.
- dsp_ack  in  1  host has consumed the character.
- dsp_data  out  DATA_W  display character.

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs empty; both FSMs idle; dout, kbd_ack, dsp_rdy, dsp_data, irq = 0; ovf_k, ovf_d, ie = 0.
- Reset mid-handshake drops kbd_ack and dsp_rdy immediately; any character in flight is lost.
- Register map, by offset from BASE_ADDR:
  - 0 KBD: read pops the RX FIFO. dout = {1'b1, zero-padded head}. If the FIFO is empty, dout = 8'h80 and nothing is popped.
  - 1 KBDCR: read gives {rx_nonempty, ovf_k, ie, rx_count[4:0]}. Write: bit5 sets ie; bit6=1 clears ovf_k.
  - 2 DSP: write pushes din[DATA_W-1:0] into the TX FIFO. If full, the write is dropped and ovf_d is set. Read gives {tx_full, 7'b0}, so the WozMon busy poll on bit7 works.
  - 3 DSPCR: read gives {tx_full, ovf_d, 1'b0, tx_count[4:0]}. Write with bit6=1 clears ovf_d.
- Bus timing:
  - All register accesses act at the posedge where addr matches.
  - dout is loaded at that same edge.
  - A non-matching address loads dout = 8'h00.
  - One pop per cycle; a read held on KBD for N cycles pops N entries (the CPU asserts each address for one cycle).
- Keyboard FSM, states K_IDLE and K_ACK:
  - K_IDLE to K_ACK when kbd_rdy=1 and the RX FIFO is not full; kbd_data is pushed at that edge and kbd_ack=1.
  - K_ACK to K_IDLE when kbd_rdy=0; kbd_ack=0.
  - kbd_rdy=1 while the FIFO is full: stay in K_IDLE (backpressure) and set ovf_k once per stalled request.
- Display FSM, states D_IDLE, D_VALID and D_WAIT:
  - D_IDLE to D_VALID when the TX FIFO is not empty and dsp_ack=0; the head is loaded into dsp_data and dsp_rdy=1.
  - D_VALID to D_WAIT on dsp_ack=1; pop the FIFO and set dsp_rdy=0.
  - D_WAIT to D_IDLE on dsp_ack=0.
  - dsp_data holds its value until the next load.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle: both happen, count unchanged. This holds when the FIFO is full, and a pop of an empty FIFO is ignored.
  - A CPU write of DSP at the edge where the FIFO is full but is also being popped is accepted.
- Pointers are log2(DEPTH)-bit wrapping counters. count is log2(DEPTH)+1 bits, so full means count == DEPTH.
- irq = ie & rx_nonempty, registered.

Decomposition:
- Package pia_pkg: register offsets (OFS_KBD=0, OFS_KBDCR=1, OFS_DSP=2, OFS_DSPCR=3), FSM state encodings, status bit positions.
- Sub-module sync_fifo #(W, DEPTH): push/pop, head, full, empty and count outputs. Instantiated twice, once for RX and once for TX.

Test Plan:
- Reset then read BASE+1 -> dout=8'h00. Read BASE+0 -> dout=8'h80, no pop.
- Host sends 'A' (7'h41) via kbd_rdy/ack -> kbd_ack high one cycle after kbd_rdy. Read BASE+1 -> 8'h81. Read BASE+0 -> 8'hC1. Read BASE+1 -> 8'h00.
- Send 5 characters with KBD_DEPTH=4 -> 5th is not acked and BASE+1 reads 8'hC4. Pop one -> 5th is acked. Write 8'h40 to BASE+1 -> ovf_k cleared.
- CPU writes 8'h0D then 8'h48 to BASE+2 with dsp_ack tied low -> dsp_rdy=1, dsp_data=7'h0D. Pulse dsp_ack -> dsp_data=7'h48 on the next presentation; FIFO order preserved.
- Write 5 characters to DSP with DSP_DEPTH=4 and host stalled -> BASE+2 read = 8'h80 after the 4th write, and the 5th is dropped. BASE+3 = 8'hC4.
- Write 8'h20 to BASE+1, then host sends a character -> irq=1. Read BASE+0 -> irq=0 the following cycle. Assert reset mid-D_VALID -> dsp_rdy=0 immediately.

Source files
------------

// File: rtl/pia_pkg.sv
// ============================================================================
// Module      : pia_pkg
// Description : Shared constants for the FIFO-buffered Apple-I style PIA.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pia_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] c_OFS_KBD   = 2'd0;
    localparam logic [1:0] c_OFS_KBDCR = 2'd1;
    localparam logic [1:0] c_OFS_DSP   = 2'd2;
    localparam logic [1:0] c_OFS_DSPCR = 2'd3;

    // Keyboard handshake FSM
    localparam logic       c_K_IDLE    = 1'b0;
    localparam logic       c_K_ACK     = 1'b1;

    // Display handshake FSM
    localparam logic [1:0] c_D_IDLE    = 2'd0;
    localparam logic [1:0] c_D_VALID   = 2'd1;
    localparam logic [1:0] c_D_WAIT    = 2'd2;

    // Status byte bit positions
    localparam int         c_BIT_RX_NE   = 7;
    localparam int         c_BIT_TX_FULL = 7;
    localparam int         c_BIT_OVF     = 6;
    localparam int         c_BIT_IE      = 5;

    // Bit7 of a KBD read marks the byte as a keyboard strobe
    localparam logic [7:0] c_KBD_FLAG  = 8'h80;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with count; push accepted when full if a pop
//               happens in the same cycle, pop of an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = DEPTH[c_AW:0];

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_pop;
    logic            w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pia_fifo.sv
// ============================================================================
// Module      : pia_fifo
// Description : Apple-I style keyboard/display PIA with RX/TX FIFOs, overflow
//               flags, fill-level readback and a keyboard interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pia_fifo
    import pia_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          DATA_W    = 7,
    parameter int          KBD_DEPTH = 4,
    parameter int          DSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic              we,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              irq,
    input  logic              kbd_rdy,
    output logic              kbd_ack,
    input  logic [DATA_W-1:0] kbd_data,
    output logic              dsp_rdy,
    input  logic              dsp_ack,
    output logic [DATA_W-1:0] dsp_data
);

    localparam int c_KW = $clog2(KBD_DEPTH);
    localparam int c_DW = $clog2(DSP_DEPTH);

    logic [15:0]       w_off_full;
    logic [1:0]        w_off;
    logic              w_hit;
    logic              w_rd;
    logic              w_wr;
    logic              w_kbd_pop;
    logic              w_kbdcr_wr;
    logic              w_dsp_wr;
    logic              w_dspcr_wr;

    logic [DATA_W-1:0] w_rx_head;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic [c_KW:0]     w_rx_count;
    logic [DATA_W-1:0] w_tx_head;
    logic              w_tx_full;
    logic              w_tx_empty;
    logic [c_DW:0]     w_tx_count;
    logic [7:0]        w_rx_head8;
    logic [4:0]        w_rx_cnt5;
    logic [4:0]        w_tx_cnt5;
    logic [7:0]        w_rdata;

    logic              r_kstate;
    logic              w_kstate_nxt;
    logic              w_rx_push;
    logic              w_kbd_stall;
    logic [1:0]        r_dstate;
    logic [1:0]        w_dstate_nxt;
    logic              w_dsp_load;
    logic              w_tx_pop;

    logic [7:0]        r_dout;
    logic              r_irq;
    logic              r_ie;
    logic              r_ovf_k;
    logic              r_ovf_d;
    logic              r_kstall;
    logic [DATA_W-1:0] r_dsp_data;
    logic              w_unused;

    // Subtracting the base keeps decoding correct for any BASE_ADDR alignment
    assign w_off_full = addr - BASE_ADDR;
    assign w_hit      = (w_off_full[15:2] == 14'd0);
    assign w_off      = w_off_full[1:0];
    assign w_rd       = w_hit & ~we;
    assign w_wr       = w_hit & we;
    assign w_kbd_pop  = w_rd & (w_off == c_OFS_KBD);
    assign w_kbdcr_wr = w_wr & (w_off == c_OFS_KBDCR);
    assign w_dsp_wr   = w_wr & (w_off == c_OFS_DSP);
    assign w_dspcr_wr = w_wr & (w_off == c_OFS_DSPCR);
    assign w_unused   = ^din;

    sync_fifo #(.W(DATA_W), .DEPTH(KBD_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_pop   (w_kbd_pop),
        .i_data  (kbd_data),
        .o_head  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    sync_fifo #(.W(DATA_W), .DEPTH(DSP_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_dsp_wr),
        .i_pop   (w_tx_pop),
        .i_data  (din[DATA_W-1:0]),
        .o_head  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    assign w_rx_cnt5 = 5'(w_rx_count);
    assign w_tx_cnt5 = 5'(w_tx_count);

    always_comb begin
        w_rx_head8               = '0;
        w_rx_head8[DATA_W-1:0]   = w_rx_head;
    end

    always_comb begin
        w_rdata = 8'h00;
        if (w_rd) begin
            case (w_off)
                c_OFS_KBD: begin
                    w_rdata = w_rx_empty ? c_KBD_FLAG : (c_KBD_FLAG | w_rx_head8);
                end
                c_OFS_KBDCR: begin
                    w_rdata[4:0]        = w_rx_cnt5;
                    w_rdata[c_BIT_IE]   = r_ie;
                    w_rdata[c_BIT_OVF]  = r_ovf_k;
                    w_rdata[c_BIT_RX_NE] = ~w_rx_empty;
                end
                c_OFS_DSP: begin
                    w_rdata[c_BIT_TX_FULL] = w_tx_full;
                end
                c_OFS_DSPCR: begin
                    w_rdata[4:0]           = w_tx_cnt5;
                    w_rdata[c_BIT_OVF]     = r_ovf_d;
                    w_rdata[c_BIT_TX_FULL] = w_tx_full;
                end
            endcase
        end
    end

    // Keyboard handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kstate <= c_K_IDLE;
        end else begin
            r_kstate <= w_kstate_nxt;
        end
    end

    always_comb begin
        w_kstate_nxt = r_kstate;
        w_rx_push    = 1'b0;
        w_kbd_stall  = 1'b0;
        if (r_kstate == c_K_IDLE) begin
            if (kbd_rdy) begin
                if (!w_rx_full) begin
                    w_rx_push    = 1'b1;
                    w_kstate_nxt = c_K_ACK;
                end else begin
                    w_kbd_stall  = 1'b1;
                end
            end
        end else begin
            if (!kbd_rdy) begin
                w_kstate_nxt = c_K_IDLE;
            end
        end
    end

    assign kbd_ack = (r_kstate == c_K_ACK);

    // Display handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dstate <= c_D_IDLE;
        end else begin
            r_dstate <= w_dstate_nxt;
        end
    end

    always_comb begin
        w_dstate_nxt = r_dstate;
        w_dsp_load   = 1'b0;
        w_tx_pop     = 1'b0;
        case (r_dstate)
            c_D_IDLE: begin
                if (!w_tx_empty && !dsp_ack) begin
                    w_dsp_load   = 1'b1;
                    w_dstate_nxt = c_D_VALID;
                end
            end
            c_D_VALID: begin
                if (dsp_ack) begin
                    w_tx_pop     = 1'b1;
                    w_dstate_nxt = c_D_WAIT;
                end
            end
            c_D_WAIT: begin
                if (!dsp_ack) begin
                    w_dstate_nxt = c_D_IDLE;
                end
            end
            default: w_dstate_nxt = c_D_IDLE;
        endcase
    end

    assign dsp_rdy  = (r_dstate == c_D_VALID);
    assign dsp_data = r_dsp_data;

    // Status, read data and interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dout     <= 8'h00;
            r_irq      <= 1'b0;
            r_ie       <= 1'b0;
            r_ovf_k    <= 1'b0;
            r_ovf_d    <= 1'b0;
            r_kstall   <= 1'b0;
            r_dsp_data <= '0;
        end else begin
            r_dout   <= w_rdata;
            r_irq    <= r_ie & ~w_rx_empty;
            r_kstall <= w_kbd_stall;
            if (w_kbdcr_wr) begin
                r_ie <= din[c_BIT_IE];
            end
            // Only the first cycle of a stalled request flags the overflow
            if (w_kbd_stall && !r_kstall) begin
                r_ovf_k <= 1'b1;
            end else if (w_kbdcr_wr && din[c_BIT_OVF]) begin
                r_ovf_k <= 1'b0;
            end
            if (w_dsp_wr && w_tx_full && !w_tx_pop) begin
                r_ovf_d <= 1'b1;
            end else if (w_dspcr_wr && din[c_BIT_OVF]) begin
                r_ovf_d <= 1'b0;
            end
            if (w_dsp_load) begin
                r_dsp_data <= w_tx_head;
            end
        end
    end

    assign dout = r_dout;
    assign irq  = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_pia_fifo.sv
// ============================================================================
// Module      : tb_pia_fifo
// Description : Self-checking bench for pia_fifo: register table, directed
//               handshake sequences and randomized traffic vs. a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pia_fifo;

    localparam logic [15:0] c_BASE = 16'hD010;
    localparam int          c_DEP  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  din;
    logic        kbd_rdy;
    logic [6:0]  kbd_data;
    logic        dsp_ack;
    logic [7:0]  dout;
    logic        irq;
    logic        kbd_ack;
    logic        dsp_rdy;
    logic [6:0]  dsp_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [6:0] m_rx[$];
    logic [6:0] m_tx[$];
    bit         m_kack, m_kstall, m_ovfk, m_ovfd, m_ie, m_irq, m_drdy, m_dwait;
    logic [7:0] m_dout;
    logic [6:0] m_ddata;

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl[12];

    pia_fifo #(
        .BASE_ADDR (c_BASE),
        .DATA_W    (7),
        .KBD_DEPTH (c_DEP),
        .DSP_DEPTH (c_DEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .irq      (irq),
        .kbd_rdy  (kbd_rdy),
        .kbd_ack  (kbd_ack),
        .kbd_data (kbd_data),
        .dsp_rdy  (dsp_rdy),
        .dsp_ack  (dsp_ack),
        .dsp_data (dsp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rx.delete();
        m_tx.delete();
        {m_kack, m_kstall, m_ovfk, m_ovfd, m_ie, m_irq, m_drdy, m_dwait} = '0;
        m_dout  = 8'h00;
        m_ddata = 7'h00;
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        logic [15:0] d;
        logic [7:0]  nd;
        bit          hit, rd, wr, tx_pop, stall;
        int          nrx, ntx;
        d      = addr - c_BASE;
        hit    = (d < 16'd4);
        rd     = hit && !we;
        wr     = hit && we;
        nrx    = m_rx.size();
        ntx    = m_tx.size();
        tx_pop = m_drdy && dsp_ack;
        nd     = 8'h00;
        if (rd) begin
            case (d[1:0])
                2'd0: nd = (nrx > 0) ? {1'b1, m_rx[0]} : 8'h80;
                2'd1: nd = {nrx > 0, m_ovfk, m_ie, 5'(nrx)};
                2'd2: nd = {ntx == c_DEP, 7'b0};
                default: nd = {ntx == c_DEP, m_ovfd, 1'b0, 5'(ntx)};
            endcase
        end
        m_irq = m_ie && (nrx > 0);
        stall = !m_kack && kbd_rdy && (nrx == c_DEP);
        if (stall && !m_kstall) m_ovfk = 1'b1;
        else if (wr && d[1:0] == 2'd1 && din[6]) m_ovfk = 1'b0;
        m_kstall = stall;
        if (wr && d[1:0] == 2'd1) m_ie = din[5];
        if (rd && d[1:0] == 2'd0 && nrx > 0) void'(m_rx.pop_front());
        if (!m_kack && kbd_rdy && nrx < c_DEP) begin
            m_rx.push_back(kbd_data);
            m_kack = 1'b1;
        end else if (m_kack && !kbd_rdy) begin
            m_kack = 1'b0;
        end
        if (m_drdy) begin
            if (dsp_ack) begin
                m_drdy  = 1'b0;
                m_dwait = 1'b1;
            end
        end else if (m_dwait) begin
            if (!dsp_ack) m_dwait = 1'b0;
        end else if (ntx > 0 && !dsp_ack) begin
            m_drdy  = 1'b1;
            m_ddata = m_tx[0];
        end
        if (tx_pop) void'(m_tx.pop_front());
        if (wr && d[1:0] == 2'd2) begin
            if (ntx < c_DEP || tx_pop) m_tx.push_back(din[6:0]);
            else m_ovfd = 1'b1;
        end
        if (wr && d[1:0] == 2'd3 && din[6]) m_ovfd = 1'b0;
        m_dout = nd;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("m_dout", dout, m_dout);
        chk("m_irq", {7'b0, irq}, {7'b0, m_irq});
        chk("m_kbd_ack", {7'b0, kbd_ack}, {7'b0, m_kack});
        chk("m_dsp_rdy", {7'b0, dsp_rdy}, {7'b0, m_drdy});
        chk("m_dsp_data", {1'b0, dsp_data}, {1'b0, m_ddata});
    endtask

    task automatic rd(input logic [1:0] off);
        addr = c_BASE + 16'(off);
        we   = 1'b0;
        cyc();
        addr = 16'h0000;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] v);
        addr = c_BASE + 16'(off);
        we   = 1'b1;
        din  = v;
        cyc();
        we   = 1'b0;
        addr = 16'h0000;
    endtask

    task automatic send(input logic [6:0] ch);
        kbd_rdy  = 1'b1;
        kbd_data = ch;
        for (int n = 0; n < 8 && !kbd_ack; n++) cyc();
        chk("send_ack", {7'b0, kbd_ack}, 8'h01);
        kbd_rdy = 1'b0;
        cyc();
    endtask

    task automatic wait_dsp_rdy();
        for (int n = 0; n < 8 && !dsp_rdy; n++) cyc();
        chk("dsp_rdy_wait", {7'b0, dsp_rdy}, 8'h01);
    endtask

    initial begin
        reset = 1'b0; addr = 16'h0000; we = 1'b0; din = 8'h00;
        kbd_rdy = 1'b0; kbd_data = 7'h00; dsp_ack = 1'b0;
        model_reset();
        tbl[0]  = '{c_BASE + 16'd1, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{c_BASE + 16'd0, 1'b0, 8'h00, 8'h80};
        tbl[2]  = '{c_BASE + 16'd2, 1'b0, 8'h00, 8'h00};
        tbl[3]  = '{c_BASE + 16'd3, 1'b0, 8'h00, 8'h00};
        tbl[4]  = '{16'h0000,       1'b0, 8'h00, 8'h00};
        tbl[5]  = '{c_BASE + 16'd4, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{c_BASE - 16'd1, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{c_BASE + 16'd1, 1'b1, 8'hFF, 8'h00};
        tbl[8]  = '{c_BASE + 16'd1, 1'b0, 8'h00, 8'h20};
        tbl[9]  = '{c_BASE + 16'd1, 1'b1, 8'h00, 8'h00};
        tbl[10] = '{c_BASE + 16'd1, 1'b0, 8'h00, 8'h00};
        tbl[11] = '{c_BASE + 16'd0, 1'b0, 8'h00, 8'h80};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_kbd_ack", {7'b0, kbd_ack}, 8'h00);
        chk("rst_dsp_rdy", {7'b0, dsp_rdy}, 8'h00);
        chk("rst_dsp_data", {1'b0, dsp_data}, 8'h00);

        for (int i = 0; i < 12; i++) begin
            addr = tbl[i].a; we = tbl[i].w; din = tbl[i].d;
            cyc();
            chk("tbl", dout, tbl[i].exp);
        end
        addr = 16'h0000; we = 1'b0;

        // Single character 'A'
        kbd_rdy = 1'b1; kbd_data = 7'h41;
        cyc();
        chk("kack_1cyc", {7'b0, kbd_ack}, 8'h01);
        kbd_rdy = 1'b0;
        cyc();
        chk("kack_drop", {7'b0, kbd_ack}, 8'h00);
        rd(2'd1); chk("kbdcr_one", dout, 8'h81);
        rd(2'd0); chk("kbd_A", dout, 8'hC1);
        rd(2'd1); chk("kbdcr_empty", dout, 8'h00);

        // RX overflow and backpressure
        for (int i = 1; i <= 4; i++) send(7'(32'h30 + i));
        kbd_rdy = 1'b1; kbd_data = 7'h35;
        repeat (3) cyc();
        chk("stall_noack", {7'b0, kbd_ack}, 8'h00);
        rd(2'd1); chk("kbdcr_ovf", dout, 8'hC4);
        rd(2'd0); chk("pop_first", dout, 8'hB1);
        cyc();
        chk("ack_after_pop", {7'b0, kbd_ack}, 8'h01);
        kbd_rdy = 1'b0;
        cyc();
        wr(2'd1, 8'h40);
        rd(2'd1); chk("ovfk_clr", dout, 8'h84);
        for (int i = 2; i <= 5; i++) begin
            rd(2'd0);
            chk("rx_drain", dout, 8'(32'hB0 + i));
        end
        rd(2'd1); chk("kbdcr_drained", dout, 8'h00);

        // Display ordering
        dsp_ack = 1'b0;
        wr(2'd2, 8'h0D);
        wr(2'd2, 8'h48);
        chk("dsp_rdy_first", {7'b0, dsp_rdy}, 8'h01);
        chk("dsp_data_0D", {1'b0, dsp_data}, 8'h0D);
        dsp_ack = 1'b1; cyc();
        chk("dsp_rdy_ack", {7'b0, dsp_rdy}, 8'h00);
        chk("dsp_data_hold", {1'b0, dsp_data}, 8'h0D);
        dsp_ack = 1'b0; cyc();
        wait_dsp_rdy();
        chk("dsp_data_48", {1'b0, dsp_data}, 8'h48);
        dsp_ack = 1'b1; cyc();
        dsp_ack = 1'b0; cyc(); cyc();
        chk("dsp_idle", {7'b0, dsp_rdy}, 8'h00);

        // TX overflow with host stalled
        for (int i = 0; i < 4; i++) wr(2'd2, 8'(32'h60 + i));
        rd(2'd2); chk("dsp_busy", dout, 8'h80);
        wr(2'd2, 8'h64);
        rd(2'd3); chk("dspcr_ovf", dout, 8'hC4);
        for (int i = 0; i < 4; i++) begin
            wait_dsp_rdy();
            chk("dsp_order", {1'b0, dsp_data}, 8'(32'h60 + i));
            dsp_ack = 1'b1; cyc();
            dsp_ack = 1'b0; cyc();
        end
        cyc();
        chk("dsp_dropped", {7'b0, dsp_rdy}, 8'h00);
        rd(2'd3); chk("dspcr_sticky", dout, 8'h40);
        wr(2'd3, 8'h40);
        rd(2'd3); chk("dspcr_clr", dout, 8'h00);

        // Interrupt
        wr(2'd1, 8'h20);
        send(7'h5A);
        chk("irq_set", {7'b0, irq}, 8'h01);
        rd(2'd0); chk("kbd_5A", dout, 8'hDA);
        cyc();
        chk("irq_clr", {7'b0, irq}, 8'h00);

        // Asynchronous reset mid-handshake
        kbd_rdy = 1'b1; kbd_data = 7'h11;
        wr(2'd2, 8'h55);
        cyc();
        chk("pre_rst_rdy", {7'b0, dsp_rdy}, 8'h01);
        chk("pre_rst_kack", {7'b0, kbd_ack}, 8'h01);
        #2 reset = 1'b0;
        #1;
        chk("arst_dsp_rdy", {7'b0, dsp_rdy}, 8'h00);
        chk("arst_kbd_ack", {7'b0, kbd_ack}, 8'h00);
        chk("arst_dsp_data", {1'b0, dsp_data}, 8'h00);
        model_reset();
        kbd_rdy = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Randomized traffic against the queue model
        for (int i = 0; i < 4000; i++) begin
            addr     = ($urandom_range(0, 9) < 8) ? c_BASE + 16'($urandom_range(0, 3))
                                                  : 16'($urandom);
            we       = ($urandom_range(0, 2) == 0);
            din      = 8'($urandom);
            kbd_rdy  = ($urandom_range(0, 7) < ((i < 2000) ? 6 : 1));
            kbd_data = 7'($urandom);
            dsp_ack  = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
